// File: rtl/id_ex_decode.sv
// RV64IM decode stage and ID/EX pipeline register.
// Decodes InstrD into ALU code, controls and immediate; registers them for execute.
module id_ex_decode #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            validD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            enableE,
  output logic [5:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            IllegalE
);

  typedef struct packed {
    logic            enable;
    logic [5:0]      alu_ctrl;
    logic            alu_src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic            jump;
    logic            branch;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
  } idex_t;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOp32  = 7'b0111011;
  localparam logic [6:0] OpcImm   = 7'b0010011;
  localparam logic [6:0] OpcImm32 = 7'b0011011;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcBr    = 7'b1100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  localparam logic [5:0] AluAdd = 6'd4;
  localparam logic [5:0] AluUpper = 6'd25;
  localparam logic [5:0] AluJump = 6'd26;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = InstrD[6:0];
  assign f3     = InstrD[14:12];
  assign f7     = InstrD[31:25];

  assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                  InstrD[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                  InstrD[30:21], 1'b0};

  logic            illegal;
  logic [5:0]      code;
  logic            alu_src, jump, branch, reg_write, mem_write;
  logic [1:0]      result_src;
  logic [XLEN-1:0] imm;
  logic            use_rs1, use_rs2, use_rd;
  idex_t           idex_d, idex_q;

  always_comb begin
    illegal    = 1'b0;
    code       = 6'd0;
    alu_src    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'd0;
    imm        = '0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    unique case (opcode)
      OpcOp: begin
        {use_rs1, use_rs2, use_rd, reg_write} = 4'b1111;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  code = 6'd4;
              3'b001:  code = 6'd1;
              3'b010:  code = 6'd17;
              3'b011:  code = 6'd18;
              3'b100:  code = 6'd14;
              3'b101:  code = 6'd2;
              3'b110:  code = 6'd15;
              default: code = 6'd16;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      code = 6'd5;
            else if (f3 == 3'b101) code = 6'd3;
            else                   illegal = 1'b1;
          end
          7'b0000001: begin
            case (f3)
              3'b000:  code = 6'd10;
              3'b001:  code = 6'd11;
              3'b010:  code = 6'd13;
              3'b011:  code = 6'd12;
              3'b100:  code = 6'd6;
              3'b101:  code = 6'd7;
              3'b110:  code = 6'd8;
              default: code = 6'd9;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      OpcOp32: begin
        {use_rs1, use_rs2, use_rd, reg_write} = 4'b1111;
        case ({f7, f3})
          {7'b0000000, 3'b000}: code = 6'd36;
          {7'b0000000, 3'b001}: code = 6'd33;
          {7'b0000000, 3'b101}: code = 6'd34;
          {7'b0100000, 3'b000}: code = 6'd37;
          {7'b0100000, 3'b101}: code = 6'd35;
          {7'b0000001, 3'b000}: code = 6'd42;
          {7'b0000001, 3'b100}: code = 6'd38;
          {7'b0000001, 3'b101}: code = 6'd39;
          {7'b0000001, 3'b110}: code = 6'd40;
          {7'b0000001, 3'b111}: code = 6'd41;
          default:              illegal = 1'b1;
        endcase
      end
      OpcImm: begin
        {use_rs1, use_rd, reg_write, alu_src} = 4'b1111;
        imm = imm_i;
        case (f3)
          3'b000: code = 6'd4;
          3'b010: code = 6'd17;
          3'b011: code = 6'd18;
          3'b100: code = 6'd14;
          3'b110: code = 6'd15;
          3'b111: code = 6'd16;
          3'b001: begin
            if (InstrD[31:26] == 6'b000000) code = 6'd1;
            else                            illegal = 1'b1;
          end
          default: begin
            if (InstrD[31:26] == 6'b000000)      code = 6'd2;
            else if (InstrD[31:26] == 6'b010000) code = 6'd3;
            else                                 illegal = 1'b1;
          end
        endcase
      end
      OpcImm32: begin
        {use_rs1, use_rd, reg_write, alu_src} = 4'b1111;
        imm = imm_i;
        if (f3 == 3'b000)                          code = 6'd36;
        else if (f3 == 3'b001 && f7 == 7'b0000000) code = 6'd33;
        else if (f3 == 3'b101 && f7 == 7'b0000000) code = 6'd34;
        else if (f3 == 3'b101 && f7 == 7'b0100000) code = 6'd35;
        else                                       illegal = 1'b1;
      end
      OpcLoad: begin
        {use_rs1, use_rd, reg_write, alu_src} = 4'b1111;
        code       = AluAdd;
        imm        = imm_i;
        result_src = 2'd1;
        illegal    = (f3 == 3'b111);
      end
      OpcStore: begin
        {use_rs1, use_rs2, mem_write, alu_src} = 4'b1111;
        code    = AluAdd;
        imm     = imm_s;
        illegal = f3[2];
      end
      OpcBr: begin
        {use_rs1, use_rs2, branch} = 3'b111;
        imm = imm_b;
        case (f3)
          3'b000:  code = 6'd19;
          3'b001:  code = 6'd20;
          3'b100:  code = 6'd21;
          3'b101:  code = 6'd22;
          3'b110:  code = 6'd23;
          3'b111:  code = 6'd24;
          default: illegal = 1'b1;
        endcase
      end
      OpcLui, OpcAuipc: begin
        {use_rd, reg_write, alu_src} = 3'b111;
        code = AluUpper;
        imm  = imm_u;
      end
      OpcJal: begin
        {use_rd, reg_write, jump, alu_src} = 4'b1111;
        code       = AluJump;
        imm        = imm_j;
        result_src = 2'd2;
      end
      OpcJalr: begin
        {use_rs1, use_rd, reg_write, jump, alu_src} = 5'b11111;
        code       = AluJump;
        imm        = imm_i;
        result_src = 2'd2;
        illegal    = (f3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal instructions keep enable and data but drop every control/index field.
  always_comb begin
    idex_d = '0;
    if (validD) begin
      idex_d.enable  = 1'b1;
      idex_d.illegal = illegal;
      idex_d.rd1     = RD1D;
      idex_d.rd2     = RD2D;
      idex_d.pc      = PCD;
      if (!illegal) begin
        idex_d.alu_ctrl   = code;
        idex_d.alu_src    = alu_src;
        idex_d.imm        = imm;
        idex_d.jump       = jump;
        idex_d.branch     = branch;
        idex_d.reg_write  = reg_write;
        idex_d.mem_write  = mem_write;
        idex_d.result_src = result_src;
        idex_d.rs1        = use_rs1 ? InstrD[19:15] : 5'd0;
        idex_d.rs2        = use_rs2 ? InstrD[24:20] : 5'd0;
        idex_d.rd         = use_rd  ? InstrD[11:7]  : 5'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else if (!StallE) begin
      idex_q <= idex_d;
    end
  end

  assign enableE     = idex_q.enable;
  assign ALUControlE = idex_q.alu_ctrl;
  assign ALUSrcE     = idex_q.alu_src;
  assign ImmExtE     = idex_q.imm;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign PCE         = idex_q.pc;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign ResultSrcE  = idex_q.result_src;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign IllegalE    = idex_q.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode: hand-computed vectors checked with immediate assertions.
module tb_id_ex_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [63:0] PCD, RD1D, RD2D;
  logic        validD, StallE, FlushE;
  logic        enableE, ALUSrcE, JumpE, BranchE, RegWriteE, MemWriteE, IllegalE;
  logic [5:0]  ALUControlE;
  logic [63:0] ImmExtE, RD1E, RD2E, PCE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_decode #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .validD(validD),
    .RD1D(RD1D), .RD2D(RD2D), .StallE(StallE), .FlushE(FlushE),
    .enableE(enableE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ImmExtE(ImmExtE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .JumpE(JumpE), .BranchE(BranchE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE)
  );

  logic [63:0] any_out;
  assign any_out = {63'd0, |{enableE, ALUControlE, ALUSrcE, ImmExtE, RD1E, RD2E, PCE,
                             JumpE, BranchE, RegWriteE, MemWriteE, ResultSrcE,
                             Rs1E, Rs2E, RdE, IllegalE}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; InstrD = 32'h0; PCD = 64'h0; validD = 1'b0;
    RD1D = 64'h0; RD2D = 64'h0; StallE = 1'b0; FlushE = 1'b0;
    #12;
    check("reset_all_zero", any_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addi x1,x0,42
    validD = 1'b1; InstrD = 32'h02A00093; PCD = 64'h40;
    check("decode_is_registered", enableE, 0);
    @(posedge clk); #1;
    check("addi_en", enableE, 1);
    check("addi_alu", ALUControlE, 4);
    check("addi_src", ALUSrcE, 1);
    check("addi_imm", ImmExtE, 42);
    check("addi_rd", RdE, 1);
    check("addi_rw", RegWriteE, 1);
    check("addi_rs2", Rs2E, 0);

    // sub x3,x1,x2
    InstrD = 32'h402081B3; RD1D = 64'd10; RD2D = 64'd3;
    @(posedge clk); #1;
    check("sub_alu", ALUControlE, 5);
    check("sub_src", ALUSrcE, 0);
    check("sub_rd1", RD1E, 10);
    check("sub_rd2", RD2E, 3);
    check("sub_rd", RdE, 3);
    check("sub_rs1", Rs1E, 1);
    check("sub_rs2", Rs2E, 2);
    check("sub_imm", ImmExtE, 0);

    // beq x1,x2,-8
    InstrD = 32'hFE208CE3; PCD = 64'h100;
    @(posedge clk); #1;
    check("beq_alu", ALUControlE, 19);
    check("beq_branch", BranchE, 1);
    check("beq_imm", ImmExtE, 64'hFFFF_FFFF_FFFF_FFF8);
    check("beq_pc", PCE, 64'h100);
    check("beq_rw", RegWriteE, 0);

    // srai x1,x1,63
    InstrD = 32'h43F0D093;
    @(posedge clk); #1;
    check("srai_alu", ALUControlE, 3);
    check("srai_shamt", ImmExtE[5:0], 63);

    // srli with reserved imm[11:6] = 100000
    InstrD = 32'h8000D093;
    @(posedge clk); #1;
    check("bad_shift_ill", IllegalE, 1);
    check("bad_shift_alu", ALUControlE, 0);

    // lui x5,0x12345
    InstrD = 32'h123452B7;
    @(posedge clk); #1;
    check("lui_alu", ALUControlE, 25);
    check("lui_imm", ImmExtE, 64'h12345000);
    check("lui_rs1", Rs1E, 0);
    check("lui_ill", IllegalE, 0);

    // jal x1,8
    InstrD = 32'h008000EF;
    @(posedge clk); #1;
    check("jal_alu", ALUControlE, 26);
    check("jal_jump", JumpE, 1);
    check("jal_res", ResultSrcE, 2);
    check("jal_imm", ImmExtE, 8);

    // ld x4,16(x2)
    InstrD = 32'h01013203;
    @(posedge clk); #1;
    check("ld_res", ResultSrcE, 1);
    check("ld_imm", ImmExtE, 16);
    check("ld_rs1", Rs1E, 2);
    check("ld_rs2", Rs2E, 0);

    // sd x5,8(x2)
    InstrD = 32'h00513423;
    @(posedge clk); #1;
    check("sd_mw", MemWriteE, 1);
    check("sd_rw", RegWriteE, 0);
    check("sd_imm", ImmExtE, 8);
    check("sd_rs2", Rs2E, 5);

    // mulw x5,x6,x7 then stall while InstrD changes
    InstrD = 32'h027302BB;
    @(posedge clk); #1;
    check("mulw_alu", ALUControlE, 42);
    check("mulw_rd", RdE, 5);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InstrD = (i == 1) ? 32'hFE208CE3 : 32'h02A00093;
      RD1D = 64'(i + 100);
      @(posedge clk); #1;
      check("stall_alu", ALUControlE, 42);
      check("stall_rd", RdE, 5);
      check("stall_rd1", RD1E, 10);
    end
    FlushE = 1'b1;
    @(posedge clk); #1;
    check("flush_en", enableE, 0);
    check("flush_all", any_out, 0);
    FlushE = 1'b0; StallE = 1'b0;

    // fetch bubble
    validD = 1'b0; InstrD = 32'h02A00093;
    @(posedge clk); #1;
    check("bubble_all", any_out, 0);

    // illegal opcode, then async reset mid-cycle
    validD = 1'b1; InstrD = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("ill_flag", IllegalE, 1);
    check("ill_en", enableE, 1);
    check("ill_alu", ALUControlE, 0);
    check("ill_rw", RegWriteE, 0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_all", any_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
